univ_reg: RTL and testbench

Parametrised universal register, the successor to the fixed 8-bit enabled register. It adds:
- generic width
- parallel load, single-bit shift and rotate modes, with serial in/out
- synchronous clear
- a multi-cycle burst-shift engine with busy/done status

Intended as the general-purpose storage/shift element in basics-level datapaths (serialisers, simple multipliers, LFSR scaffolds).

---
 rtl/univ_reg_if.sv | 26 ++
 rtl/univ_reg.sv | 117 +++++++++++
 tb/tb_univ_reg.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/univ_reg_if.sv
// Bus bundle for univ_reg: operation request signals in, register/status out.
interface univ_reg_if #(
    parameter int N  = 8,
    parameter int AW = $clog2(N) + 1
);
    logic          en;
    logic [2:0]    mode;
    logic [N-1:0]  d;
    logic          sin;
    logic          dir;
    logic [AW-1:0] amt;
    logic [N-1:0]  q;
    logic          sout;
    logic          busy;
    logic          done;

    modport master (
        output en, mode, d, sin, dir, amt,
        input  q, sout, busy, done
    );

    modport slave (
        input  en, mode, d, sin, dir, amt,
        output q, sout, busy, done
    );
endinterface

// File: rtl/univ_reg.sv
// Universal register: load, shift, rotate and clear, plus a multi-cycle burst-shift engine.
//
// state   | meaning
// S_IDLE  | single-cycle operations accepted when en=1
// S_BURST | shifting once per edge until the remaining count runs out
module univ_reg #(
    parameter int           N       = 8,
    parameter logic [N-1:0] RST_VAL = '0,
    parameter int           AW      = $clog2(N) + 1
) (
    input  logic        clk,
    input  logic        rst,
    univ_reg_if.slave   bus
);
    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROTL  = 3'b100;
    localparam logic [2:0] M_ROTR  = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;
    localparam logic [2:0] M_BURST = 3'b111;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t        state, state_n;
    logic [N-1:0]  q_r, q_n;
    logic          sout_r, sout_n;
    logic          done_r, done_n;
    logic [AW-1:0] rem, rem_n;
    logic          dir_l, dir_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            q_r    <= RST_VAL;
            sout_r <= 1'b0;
            done_r <= 1'b0;
            rem    <= '0;
            dir_l  <= 1'b0;
        end else begin
            state  <= state_n;
            q_r    <= q_n;
            sout_r <= sout_n;
            done_r <= done_n;
            rem    <= rem_n;
            dir_l  <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q_r;
        sout_n  = sout_r;
        done_n  = 1'b0;
        rem_n   = rem;
        dir_n   = dir_l;
        case (state)
            S_IDLE: begin
                if (bus.en) begin
                    case (bus.mode)
                        M_HOLD: ;
                        M_LOAD: q_n = bus.d;
                        M_SHL: begin
                            q_n    = {q_r[N-2:0], bus.sin};
                            sout_n = q_r[N-1];
                        end
                        M_SHR: begin
                            q_n    = {bus.sin, q_r[N-1:1]};
                            sout_n = q_r[0];
                        end
                        M_ROTL: begin
                            q_n    = {q_r[N-2:0], q_r[N-1]};
                            sout_n = q_r[N-1];
                        end
                        M_ROTR: begin
                            q_n    = {q_r[0], q_r[N-1:1]};
                            sout_n = q_r[0];
                        end
                        M_CLEAR: begin
                            q_n    = '0;
                            sout_n = 1'b0;
                        end
                        M_BURST: begin
                            rem_n = bus.amt;
                            dir_n = bus.dir;
                            // A zero-length burst completes immediately without ever going busy
                            if (bus.amt != '0) state_n = S_BURST;
                            else               done_n  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_BURST: begin
                if (dir_l) begin
                    q_n    = {1'b0, q_r[N-1:1]};
                    sout_n = q_r[0];
                end else begin
                    q_n    = {q_r[N-2:0], 1'b0};
                    sout_n = q_r[N-1];
                end
                rem_n = rem - AW'(1);
                if (rem == AW'(1)) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.q    = q_r;
    assign bus.sout = sout_r;
    assign bus.busy = (state == S_BURST);
    assign bus.done = done_r;
endmodule

// File: tb/tb_univ_reg.sv
// Self-checking bench for univ_reg: directed scenarios with literal expectations, then random traffic.
module tb_univ_reg;
    localparam int          N       = 8;
    localparam int          AW      = $clog2(N) + 1;
    localparam logic [N-1:0] RST_VAL = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    univ_reg_if #(.N(N), .AW(AW)) bus ();

    univ_reg #(.N(N), .RST_VAL(RST_VAL), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: register value, last bit out, remaining burst count, done pulse
    logic [N-1:0] m_q    = RST_VAL;
    logic         m_sout = 1'b0;
    int           m_rem  = 0;
    logic         m_dir  = 1'b0;
    logic         m_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] nq;
        logic         ns;
        logic         nd;
        int           nr;
        nq = m_q; ns = m_sout; nd = 1'b0; nr = m_rem;
        if (m_rem != 0) begin
            if (m_dir) begin ns = m_q[0];   nq = m_q >> 1; end
            else       begin ns = m_q[N-1]; nq = m_q << 1; end
            nr = m_rem - 1;
            if (m_rem == 1) nd = 1'b1;
        end else if (bus.en) begin
            case (bus.mode)
                3'd1: nq = bus.d;
                3'd2: begin ns = m_q[N-1]; nq = (m_q << 1) | N'(bus.sin); end
                3'd3: begin ns = m_q[0];   nq = (m_q >> 1) | (N'(bus.sin) << (N-1)); end
                3'd4: begin ns = m_q[N-1]; nq = (m_q << 1) | N'(m_q[N-1]); end
                3'd5: begin ns = m_q[0];   nq = (m_q >> 1) | (N'(m_q[0]) << (N-1)); end
                3'd6: begin ns = 1'b0;     nq = '0; end
                3'd7: begin
                    m_dir = bus.dir;
                    nr    = int'(bus.amt);
                    if (bus.amt == 0) nd = 1'b1;
                end
                default: ;
            endcase
        end
        m_q = nq; m_sout = ns; m_done = nd; m_rem = nr;
    endtask

    always @(negedge rst) begin
        m_q = RST_VAL; m_sout = 1'b0; m_rem = 0; m_done = 1'b0;
    end

    // Cycle-by-cycle comparison against the model
    always @(posedge clk) begin
        if (rst) model_step();
        #1;
        check("q",    32'(bus.q),    32'(m_q));
        check("sout", 32'(bus.sout), 32'(m_sout));
        check("busy", 32'(bus.busy), 32'(m_rem != 0));
        check("done", 32'(bus.done), 32'(m_done));
    end

    task automatic drive(input logic e, input logic [2:0] m, input logic [N-1:0] dd,
                         input logic s, input logic dr, input logic [AW-1:0] a);
        bus.en = e; bus.mode = m; bus.d = dd; bus.sin = s; bus.dir = dr; bus.amt = a;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 3'd1, 8'hA5, 1'b0, 1'b0, '0);
        cyc(); cyc();
        check("rst_q", 32'(bus.q), 32'h00);
        check("rst_sout", 32'(bus.sout), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        rst = 1'b1;
        drive(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0, '0);
        cyc();
        check("load_3c", 32'(bus.q), 32'h3C);
        #2 rst = 1'b0;
        #1 check("async_rst_q", 32'(bus.q), 32'h00);
        cyc(); rst = 1'b1;

        drive(1'b1, 3'd1, 8'h96, 1'b0, 1'b0, '0); cyc();
        check("load_96", 32'(bus.q), 32'h96);
        drive(1'b0, 3'd1, 8'hFF, 1'b0, 1'b0, '0); cyc(); cyc(); cyc();
        check("hold_en0", 32'(bus.q), 32'h96);
        drive(1'b1, 3'd0, 8'hFF, 1'b0, 1'b0, '0); cyc();
        check("hold_mode0", 32'(bus.q), 32'h96);
        drive(1'b1, 3'd2, 8'h00, 1'b1, 1'b0, '0); cyc();
        check("shl_q", 32'(bus.q), 32'h2D);
        check("shl_sout", 32'(bus.sout), 1);
        drive(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, '0); cyc();
        check("shr_q", 32'(bus.q), 32'h16);
        check("shr_sout", 32'(bus.sout), 1);
        drive(1'b1, 3'd1, 8'h81, 1'b0, 1'b0, '0); cyc();
        drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, '0); cyc();
        check("rotl_q", 32'(bus.q), 32'h03);
        check("rotl_sout", 32'(bus.sout), 1);
        drive(1'b1, 3'd5, 8'h00, 1'b0, 1'b0, '0); cyc();
        check("rotr_q", 32'(bus.q), 32'h81);
        check("rotr_sout", 32'(bus.sout), 1);
        drive(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, '0); cyc();
        check("clear_q", 32'(bus.q), 32'h00);
        check("clear_sout", 32'(bus.sout), 0);

        // Burst left by 3 from B1 with shl requests while busy
        drive(1'b1, 3'd1, 8'hB1, 1'b0, 1'b0, '0); cyc();
        drive(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 4'd3); cyc();
        check("bl_start_busy", 32'(bus.busy), 1);
        check("bl_start_q", 32'(bus.q), 32'hB1);
        drive(1'b1, 3'd2, 8'h00, 1'b1, 1'b1, 4'd9); cyc();
        check("bl_q1", 32'(bus.q), 32'h62);
        check("bl_sout1", 32'(bus.sout), 1);
        cyc();
        check("bl_q2", 32'(bus.q), 32'hC4);
        check("bl_sout2", 32'(bus.sout), 0);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, '0); cyc();
        check("bl_q3", 32'(bus.q), 32'h88);
        check("bl_sout3", 32'(bus.sout), 1);
        check("bl_busy3", 32'(bus.busy), 0);
        check("bl_done3", 32'(bus.done), 1);
        cyc();
        check("bl_done_off", 32'(bus.done), 0);

        drive(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 4'd0); cyc();
        check("amt0_busy", 32'(bus.busy), 0);
        check("amt0_done", 32'(bus.done), 1);
        check("amt0_q", 32'(bus.q), 32'h88);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, '0); cyc();
        check("amt0_done_off", 32'(bus.done), 0);

        // Burst right by 10 on FF: empties after 8 shifts, busy for the full count
        drive(1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, '0); cyc();
        drive(1'b1, 3'd7, 8'h00, 1'b0, 1'b1, 4'd10); cyc();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 10; k++) begin
            logic [N-1:0] ff;
            ff = 8'hFF;
            cyc();
            check("br10_q", 32'(bus.q), 32'(ff >> k));
            check("br10_busy", 32'(bus.busy), 32'(k < 10));
        end
        check("br10_done", 32'(bus.done), 1);
        check("br10_sout", 32'(bus.sout), 0);

        // Reset during a burst of 5
        drive(1'b1, 3'd1, 8'hF0, 1'b0, 1'b0, '0); cyc();
        drive(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 4'd5); cyc();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, '0); cyc(); cyc();
        check("mid_q_before", 32'(bus.q), 32'hC0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_done", 32'(bus.done), 0);
        check("mid_rst_q", 32'(bus.q), 32'h00);
        cyc(); rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("mid_no_done", 32'(bus.done), 0);
        end

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom), 1'($urandom), 4'($urandom));
            if ($urandom_range(0, 99) < 2) begin
                #2 rst = 1'b0;
                cyc();
                rst = 1'b1;
            end else begin
                cyc();
            end
        end

        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, '0);
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
